master_control_fsm: RTL and testbench

- Upstream controller for the LED sequencer; produces the 2-bit MASTER_CONTROL code it consumes and reads back its STATE_OUT.
- Debounces four push-buttons and checks a fixed entry code: R, L, U, D.
- On a correct code, issues RUN (2'b11) and waits for the sequencer to acknowledge by leaving state 0.
- Monitors the sequencer until it reaches its final state; locks out after repeated wrong codes.

---
 rtl/master_control_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_master_control_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/master_control_fsm.sv
// Entry-code controller for the LED sequencer: it debounces four buttons, checks the R-L-U-D code, launches the sequencer and watches it.
// Optional per-press entry timeout: define MASTER_ENTRY_TIMEOUT_EN to enable it.
module master_control_fsm #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 500000000,
    parameter int ACK_TIMEOUT     = 16,
    parameter int FINAL_LED_STATE = 8,
    parameter int ENTRY_TIMEOUT   = 500000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_R,
    input  logic       BTN_L,
    input  logic       BTN_U,
    input  logic       BTN_D,
    input  logic [3:0] LED_STATE_IN,
    output logic [1:0] MASTER_CONTROL,
    output logic [3:0] MASTER_STATE_OUT,
    output logic       BUSY
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_GOT_R   = 4'd1;
    localparam logic [3:0] S_GOT_L   = 4'd2;
    localparam logic [3:0] S_GOT_U   = 4'd3;
    localparam logic [3:0] S_LAUNCH  = 4'd4;
    localparam logic [3:0] S_MONITOR = 4'd5;
    localparam logic [3:0] S_DONE    = 4'd6;
    localparam logic [3:0] S_LOCKOUT = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(MAX_ATTEMPTS);
    localparam logic [ATT_W-1:0]  ATT_LAST  = ATT_W'(MAX_ATTEMPTS - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]        FINAL_ST  = 4'(FINAL_LED_STATE);

    // Bit order {D, U, L, R}; one-hot values are the code symbols.
    localparam logic [3:0] P_R = 4'b0001;
    localparam logic [3:0] P_L = 4'b0010;
    localparam logic [3:0] P_U = 4'b0100;
    localparam logic [3:0] P_D = 4'b1000;

    logic [3:0] btn_raw;
    logic [3:0] press_pulse;

    assign btn_raw = {BTN_D, BTN_U, BTN_L, BTN_R};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic             sync1_q, sync2_q, press_q, press_d;
            logic [DEB_W-1:0] cnt_q, cnt_d;

            // The count saturates at DEB_MAX, so a held button fires only once.
            always_comb begin
                cnt_d   = '0;
                press_d = 1'b0;
                if (sync2_q) begin
                    cnt_d   = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
                    press_d = (cnt_q == DEB_MAX - 1'b1);
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign press_pulse[gi] = press_q;
        end
    endgenerate

    logic [3:0]        state_q, state_d;
    logic [ATT_W-1:0]  att_q, att_d;
    logic [ACK_W-1:0]  ack_q, ack_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              busy_q, busy_d;
    logic [3:0]        expect_press;
    logic [3:0]        next_code_state;

`ifdef MASTER_ENTRY_TIMEOUT_EN
    localparam int ENT_W = $clog2(ENTRY_TIMEOUT + 1);
    localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(ENTRY_TIMEOUT - 1);
    logic [ENT_W-1:0] entry_q, entry_d;
`endif

    always_comb begin
        expect_press    = P_R;
        next_code_state = S_GOT_R;
        case (state_q)
            S_GOT_R: begin expect_press = P_L; next_code_state = S_GOT_L;  end
            S_GOT_L: begin expect_press = P_U; next_code_state = S_GOT_U;  end
            S_GOT_U: begin expect_press = P_D; next_code_state = S_LAUNCH; end
            default: begin expect_press = P_R; next_code_state = S_GOT_R;  end
        endcase
    end

    always_comb begin
        state_d = state_q;
        att_d   = att_q;
        ack_d   = ack_q;
        lock_d  = lock_q;
`ifdef MASTER_ENTRY_TIMEOUT_EN
        entry_d = entry_q;
`endif
        case (state_q)
            S_IDLE, S_GOT_R, S_GOT_L, S_GOT_U: begin
                if (|press_pulse) begin
`ifdef MASTER_ENTRY_TIMEOUT_EN
                    entry_d = '0;
`endif
                    if (press_pulse == expect_press) begin
                        state_d = next_code_state;
                        if (state_q == S_GOT_U) begin
                            att_d = '0;
                            ack_d = '0;
                        end
                    end else begin
                        // Simultaneous pulses fall through here as one wrong press.
                        att_d = (att_q == ATT_MAX) ? att_q : att_q + 1'b1;
                        if (att_q == ATT_LAST) begin
                            state_d = S_LOCKOUT;
                            lock_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
`ifdef MASTER_ENTRY_TIMEOUT_EN
                else if (state_q != S_IDLE) begin
                    if (entry_q == ENT_LAST) begin
                        state_d = S_IDLE;
                        entry_d = '0;
                    end else begin
                        entry_d = entry_q + 1'b1;
                    end
                end
`endif
            end
            S_LAUNCH: begin
                if (LED_STATE_IN != 4'd0) begin
                    state_d = S_MONITOR;
                end else if (ack_q == ACK_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            S_MONITOR: begin
                if (LED_STATE_IN == FINAL_ST) begin
                    state_d = S_DONE;
                end else if (LED_STATE_IN > FINAL_ST || LED_STATE_IN == 4'd0) begin
                    state_d = S_ERROR;
                end
            end
            S_LOCKOUT: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    att_d   = '0;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            S_DONE, S_ERROR: state_d = state_q;
            default:         state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        ctrl_d = 2'b00;
        busy_d = 1'b0;
        case (state_d)
            S_GOT_R, S_GOT_L, S_GOT_U: ctrl_d = 2'b01;
            S_LAUNCH, S_MONITOR: begin
                ctrl_d = 2'b11;
                busy_d = 1'b1;
            end
            S_LOCKOUT, S_ERROR: ctrl_d = 2'b10;
            default: ctrl_d = 2'b00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            att_q   <= '0;
            ack_q   <= '0;
            lock_q  <= '0;
            ctrl_q  <= 2'b00;
            busy_q  <= 1'b0;
`ifdef MASTER_ENTRY_TIMEOUT_EN
            entry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            att_q   <= att_d;
            ack_q   <= ack_d;
            lock_q  <= lock_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
`ifdef MASTER_ENTRY_TIMEOUT_EN
            entry_q <= entry_d;
`endif
        end
    end

    assign MASTER_CONTROL   = ctrl_q;
    assign MASTER_STATE_OUT = state_q;
    assign BUSY             = busy_q;

endmodule

// File: tb/tb_master_control_fsm.sv
// Directed bench for master_control_fsm: a vector table for code entry and lockout,
// followed by hand-written sequences for the timing corner cases.
module tb_master_control_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BTN_R = 1'b0, BTN_L = 1'b0, BTN_U = 1'b0, BTN_D = 1'b0;
    logic [3:0] LED_STATE_IN;
    logic [1:0] MASTER_CONTROL;
    logic [3:0] MASTER_STATE_OUT;
    logic       BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    master_control_fsm #(
        .DEBOUNCE_CYCLES(4),
        .MAX_ATTEMPTS   (3),
        .LOCKOUT_CYCLES (20),
        .ACK_TIMEOUT    (5),
        .FINAL_LED_STATE(8),
        .ENTRY_TIMEOUT  (30)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .BTN_R           (BTN_R),
        .BTN_L           (BTN_L),
        .BTN_U           (BTN_U),
        .BTN_D           (BTN_D),
        .LED_STATE_IN    (LED_STATE_IN),
        .MASTER_CONTROL  (MASTER_CONTROL),
        .MASTER_STATE_OUT(MASTER_STATE_OUT),
        .BUSY            (BUSY)
    );

    // Sequencer model: acknowledges with state 1 two cycles after it sees LAUNCH.
    logic       ack_model_en = 1'b0;
    logic [3:0] model_led    = 4'd0;
    logic [3:0] tb_led       = 4'd0;
    int         launch_seen  = 0;

    assign LED_STATE_IN = ack_model_en ? model_led : tb_led;

    always @(negedge CLK) begin
        if (!ack_model_en) begin
            model_led   <= 4'd0;
            launch_seen <= 0;
        end else if (MASTER_STATE_OUT == 4'd4) begin
            launch_seen <= launch_seen + 1;
            if (launch_seen == 1) model_led <= 4'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] st, input logic [1:0] ctrl, input logic busy);
        check({name, ".state"}, 32'(MASTER_STATE_OUT), 32'(st));
        check({name, ".ctrl"},  32'(MASTER_CONTROL),   32'(ctrl));
        check({name, ".busy"},  32'(BUSY),             32'(busy));
    endtask

    task automatic set_btn(input logic [3:0] m);
        BTN_R = m[0];
        BTN_L = m[1];
        BTN_U = m[2];
        BTN_D = m[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int rel);
        @(negedge CLK);
        set_btn(m);
        repeat (hold) @(negedge CLK);
        set_btn(4'b0000);
        repeat (rel) @(negedge CLK);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (n) @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        int         hold;
        int         rel;
        logic       model;
        logic [3:0] led;
        int         wait_cyc;
        logic [3:0] st;
        logic [1:0] ctrl;
        logic       busy;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    localparam logic [3:0] BR = 4'b0001, BL = 4'b0010, BU = 4'b0100, BD = 4'b1000;

    initial begin
        int  n;
        bit  found;

        //          rst  btn  hold rel model led  wait  st     ctrl   busy
        vecs[0]  = '{1'b0, BR, 10, 10, 1'b1, 4'd0, 0, 4'd1, 2'b01, 1'b0};
        vecs[1]  = '{1'b0, BL, 10, 10, 1'b1, 4'd0, 0, 4'd2, 2'b01, 1'b0};
        vecs[2]  = '{1'b0, BU, 10, 10, 1'b1, 4'd0, 0, 4'd3, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, BD, 10, 10, 1'b1, 4'd0, 0, 4'd5, 2'b11, 1'b1};
        vecs[4]  = '{1'b0, 4'd0, 0, 0, 1'b0, 4'd8, 3, 4'd6, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, BR, 10, 10, 1'b0, 4'd8, 0, 4'd6, 2'b00, 1'b0};
        vecs[6]  = '{1'b1, BU, 10, 10, 1'b0, 4'd0, 0, 4'd0, 2'b00, 1'b0};
        vecs[7]  = '{1'b0, BU, 10, 10, 1'b0, 4'd0, 0, 4'd0, 2'b00, 1'b0};
        vecs[8]  = '{1'b0, BU, 10,  2, 1'b0, 4'd0, 0, 4'd7, 2'b10, 1'b0};
        vecs[9]  = '{1'b0, BR,  8,  2, 1'b0, 4'd0, 0, 4'd7, 2'b10, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 0, 0, 1'b0, 4'd0, 6, 4'd0, 2'b00, 1'b0};
        vecs[11] = '{1'b0, BR, 10, 10, 1'b1, 4'd0, 0, 4'd1, 2'b01, 1'b0};
        vecs[12] = '{1'b0, BL, 10, 10, 1'b1, 4'd0, 0, 4'd2, 2'b01, 1'b0};
        vecs[13] = '{1'b0, BU, 10, 10, 1'b1, 4'd0, 0, 4'd3, 2'b01, 1'b0};
        vecs[14] = '{1'b0, BD, 10, 10, 1'b1, 4'd0, 0, 4'd5, 2'b11, 1'b1};

        // Reset state
        do_reset(3);
        check_out("reset", 4'd0, 2'b00, 1'b0);
        $display("reset: state=%0d ctrl=%b busy=%b", MASTER_STATE_OUT, MASTER_CONTROL, BUSY);

        // Table: clean code, DONE, lockout and recovery
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst) do_reset(2);
            ack_model_en = vecs[i].model;
            tb_led       = vecs[i].led;
            if (vecs[i].btn != 4'd0) press(vecs[i].btn, vecs[i].hold, vecs[i].rel);
            else repeat (vecs[i].wait_cyc) @(negedge CLK);
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].busy);
            $display("vec %0d: btn=%b led=%0d state=%0d ctrl=%b busy=%b",
                     i, vecs[i].btn, LED_STATE_IN, MASTER_STATE_OUT, MASTER_CONTROL, BUSY);
        end
        ack_model_en = 1'b0;
        tb_led       = 4'd0;

        // Glitch rejection, then a long hold gives exactly one pulse
        do_reset(2);
        @(negedge CLK);
        BTN_R = 1'b1;
        repeat (3) @(negedge CLK);
        BTN_R = 1'b0;
        repeat (15) @(negedge CLK);
        check("glitch_short", 32'(MASTER_STATE_OUT), 32'd0);
        press(BR, 20, 10);
        check("glitch_long", 32'(MASTER_STATE_OUT), 32'd1);
        $display("glitch: state=%0d", MASTER_STATE_OUT);

        // Ack timeout: ERROR exactly 5 cycles after entering LAUNCH
        do_reset(2);
        press(BR, 10, 10);
        press(BL, 10, 10);
        press(BU, 10, 10);
        @(negedge CLK);
        BTN_D = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge CLK);
            if (MASTER_STATE_OUT == 4'd4) found = 1'b1;
        end
        check("launch_reached", 32'(found), 32'd1);
        check_out("launch", 4'd4, 2'b11, 1'b1);
        n = 0;
        while (MASTER_STATE_OUT != 4'd8 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        BTN_D = 1'b0;
        check("ack_timeout_cycles", 32'(n), 32'd5);
        check_out("error", 4'd8, 2'b10, 1'b0);
        press(BR, 10, 10);
        check("error_terminal", 32'(MASTER_STATE_OUT), 32'd8);
        do_reset(1);
        check_out("reset_1cyc", 4'd0, 2'b00, 1'b0);
        $display("ack timeout: cycles=%0d state=%0d", n, MASTER_STATE_OUT);

        // Simultaneous R+L counts as one wrong press
        do_reset(2);
        press(BR | BL, 10, 10);
        check("simul_rl", 32'(MASTER_STATE_OUT), 32'd0);
        press(BU, 10, 10);
        check("simul_wrong2", 32'(MASTER_STATE_OUT), 32'd0);
        press(BU, 10, 10);
        check("simul_lock", 32'(MASTER_STATE_OUT), 32'd7);
        $display("simultaneous: state=%0d", MASTER_STATE_OUT);

        // Reset in MONITOR returns to IDLE on the next edge
        do_reset(2);
        ack_model_en = 1'b1;
        press(BR, 10, 10);
        press(BL, 10, 10);
        press(BU, 10, 10);
        press(BD, 10, 10);
        check("monitor_before_reset", 32'(MASTER_STATE_OUT), 32'd5);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check_out("reset_in_monitor", 4'd0, 2'b00, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        ack_model_en = 1'b0;
        $display("reset in monitor: state=%0d", MASTER_STATE_OUT);

        // Entry timeout (only effective with the optional feature)
        do_reset(2);
        @(negedge CLK);
        BTN_R = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge CLK);
            if (MASTER_STATE_OUT == 4'd1) found = 1'b1;
        end
        BTN_R = 1'b0;
        check("entry_got_r", 32'(found), 32'd1);
        repeat (29) @(negedge CLK);
        check("entry_before_timeout", 32'(MASTER_STATE_OUT), 32'd1);
        @(negedge CLK);
`ifdef MASTER_ENTRY_TIMEOUT_EN
        check("entry_timeout", 32'(MASTER_STATE_OUT), 32'd0);
`else
        check("entry_no_timeout", 32'(MASTER_STATE_OUT), 32'd1);
`endif
        press(BU, 10, 10);
        press(BU, 10, 10);
        check("entry_attempts", 32'(MASTER_STATE_OUT), 32'd0);
        $display("entry timeout: state=%0d", MASTER_STATE_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
